// File: rtl/child_launch_sequencer.sv
// Run-control sequencer: starts the enabled children one at a time, lowest index
// first, waits for each done, and aborts the run when a child overruns its timeout.
module child_launch_sequencer #(
  parameter int NUM_CHILD = 5,
  parameter int TIMEOUT_W = 8,
  localparam int IDX_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go_i,
  input  logic [NUM_CHILD-1:0] mask_i,
  input  logic [TIMEOUT_W-1:0] timeout_limit_i,
  input  logic [NUM_CHILD-1:0] child_done_i,
  output logic [NUM_CHILD-1:0] child_start_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [IDX_W-1:0]     fail_idx_o,
  output logic [NUM_CHILD-1:0] completed_o
);

  // Child handshake: child_start_o[i] is a single-cycle request pulse; the child
  // answers with child_done_i[i] no earlier than the cycle after the pulse, and
  // the answer is only honoured while the sequencer is waiting on that child.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [TIMEOUT_W-1:0]   timer_q, timer_d;
  logic [NUM_CHILD-1:0]   mask_q, mask_d;
  logic [NUM_CHILD-1:0]   start_q, start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
  logic [IDX_W-1:0]       fail_idx_q, fail_idx_d;
  logic [NUM_CHILD-1:0]   completed_q, completed_d;
  logic [IDX_W:0]         hit;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [IDX_W:0] find_set(input logic [NUM_CHILD-1:0] m,
                                               input int from);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_CHILD - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    mask_d      = mask_q;
    timeout_d   = timeout_q;
    fail_idx_d  = fail_idx_q;
    completed_d = completed_q;
    start_d     = '0;
    // IDLE searches the incoming mask; NEXT searches the latched one above idx.
    if (state_q == S_IDLE) hit = find_set(mask_i, 0);
    else                   hit = find_set(mask_q, int'(idx_q) + 1);

    case (state_q)
      S_IDLE: begin
        if (go_i) begin
          mask_d      = mask_i;
          timeout_d   = 1'b0;
          fail_idx_d  = '0;
          completed_d = '0;
          if (hit[IDX_W]) begin
            idx_d   = hit[IDX_W-1:0];
            state_d = S_LAUNCH;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (child_done_i[idx_q]) begin
          completed_d[idx_q] = 1'b1;
          state_d            = S_NEXT;
        end else if ((timeout_limit_i != '0) &&
                     (timer_q == (timeout_limit_i - TIMEOUT_W'(1)))) begin
          timeout_d  = 1'b1;
          fail_idx_d = idx_q;
          state_d    = S_FINISH;
        end else if (timeout_limit_i != '0) begin
          timer_d = timer_q + TIMEOUT_W'(1);
        end else if (timer_q != '1) begin
          // No limit: count up and park at all-ones while waiting forever.
          timer_d = timer_q + TIMEOUT_W'(1);
        end
      end
      S_NEXT: begin
        if (hit[IDX_W]) begin
          idx_d   = hit[IDX_W-1:0];
          state_d = S_LAUNCH;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Moore outputs are registered from the state being entered.
    if (state_d == S_LAUNCH) start_d[idx_d] = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      mask_q      <= '0;
      start_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_idx_q  <= '0;
      completed_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      mask_q      <= mask_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      fail_idx_q  <= fail_idx_d;
      completed_q <= completed_d;
    end
  end

  assign child_start_o = start_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign fail_idx_o    = fail_idx_q;
  assign completed_o   = completed_q;

endmodule

// File: tb/tb_child_launch_sequencer.sv
// Self-checking bench for child_launch_sequencer: directed scenarios plus random
// runs compared against an event-level model of the launch/wait/finish timeline.
module tb_child_launch_sequencer;
  localparam int NC = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          go_i;
  logic [NC-1:0] mask_i;
  logic [7:0]    timeout_limit_i;
  logic [NC-1:0] child_done_i;
  logic [NC-1:0] child_start_o;
  logic          busy_o;
  logic          done_o;
  logic          timeout_o;
  logic [2:0]    fail_idx_o;
  logic [NC-1:0] completed_o;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];  // {cycle[15:0], kind}: kind = start one-hot, or 8'h80 for done_o

  child_launch_sequencer #(.NUM_CHILD(NC), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .go_i(go_i), .mask_i(mask_i),
    .timeout_limit_i(timeout_limit_i), .child_done_i(child_done_i),
    .child_start_o(child_start_o), .busy_o(busy_o), .done_o(done_o),
    .timeout_o(timeout_o), .fail_idx_o(fail_idx_o), .completed_o(completed_o)
  );

  always #5 clk = ~clk;

  // One full run: cycle 0 is the go-accept cycle. Children answer dly[i] cycles
  // after their start pulse (0 = never). align=0 issues go in the current cycle.
  task automatic run_seq(input string name, input logic [NC-1:0] mask,
                         input logic [7:0] limit, input int dly[NC],
                         input logic [NC-1:0] noise, input bit go_hold, input bit align);
    int s, cyc, exp_fail;
    int launch[NC];
    logic [NC-1:0] exp_comp, resp;
    bit exp_to, seen;
    logic [23:0] ev, exp_ev;
    s = 1; exp_comp = '0; exp_to = 0; exp_fail = 0;
    exp_q.delete();
    for (int i = 0; i < NC; i++) begin
      if (mask[i]) begin
        exp_q.push_back({16'(s), 8'(1 << i)});
        if (limit != 0 && (dly[i] == 0 || dly[i] > int'(limit))) begin
          exp_to = 1; exp_fail = i; s = s + int'(limit) + 1;
          break;
        end
        exp_comp[i] = 1'b1;
        s = s + dly[i] + 2;
      end
    end
    exp_q.push_back({16'(s), 8'h80});

    if (align) begin @(posedge clk); #1; end
    for (int i = 0; i < NC; i++) launch[i] = -1;
    mask_i = mask; timeout_limit_i = limit; go_i = 1'b1; child_done_i = noise;
    cyc = 0; seen = 0;
    while (!seen && cyc < s + 10) begin
      @(posedge clk); #1; cyc++;
      if (!go_hold) go_i = 1'b0;
      checks++;
      if (busy_o !== (cyc <= s)) begin
        errors++; $display("FAIL %s busy cyc %0d: got %b expected %b", name, cyc, busy_o, cyc <= s);
      end
      if (child_start_o != '0) begin
        ev = {16'(cyc), 3'b000, child_start_o};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s start_event: got %h expected none", name, ev);
        end else begin
          exp_ev = exp_q.pop_front();
          if (ev !== exp_ev) begin
            errors++; $display("FAIL %s start_event: got %h expected %h", name, ev, exp_ev);
          end
        end
        for (int i = 0; i < NC; i++) if (child_start_o[i]) launch[i] = cyc;
      end
      if (done_o) begin
        ev = {16'(cyc), 8'h80};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s done_event: got %h expected none", name, ev);
        end else begin
          exp_ev = exp_q.pop_front();
          if (ev !== exp_ev) begin
            errors++; $display("FAIL %s done_event: got %h expected %h", name, ev, exp_ev);
          end
        end
        seen = 1; go_i = 1'b0;
      end
      resp = '0;
      for (int i = 0; i < NC; i++)
        if (launch[i] >= 0 && dly[i] != 0 && cyc == launch[i] + dly[i]) resp[i] = 1'b1;
      child_done_i = noise | resp;
    end
    child_done_i = '0; go_i = 1'b0;
    if (!seen) begin
      errors++; $display("FAIL %s run_timeout: got no done_o by cycle %0d expected cycle %0d", name, cyc, s);
    end
    while (exp_q.size() > 0) begin
      exp_ev = exp_q.pop_front();
      errors++; $display("FAIL %s missing_event: got nothing expected %h", name, exp_ev);
    end
    checks++;
    if (completed_o !== exp_comp || timeout_o !== exp_to || fail_idx_o !== 3'(exp_fail)) begin
      errors++;
      $display("FAIL %s status: got comp=%b to=%b idx=%0d expected comp=%b to=%b idx=%0d",
               name, completed_o, timeout_o, fail_idx_o, exp_comp, exp_to, exp_fail);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || child_start_o !== '0 || completed_o !== exp_comp) begin
      errors++;
      $display("FAIL %s idle_after: got busy=%b done=%b start=%b comp=%b expected 0 0 00000 %b",
               name, busy_o, done_o, child_start_o, completed_o, exp_comp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; go_i = 1'b0; mask_i = '0; timeout_limit_i = '0; child_done_i = '0;
    #2;
    checks++;
    if ({child_start_o, busy_o, done_o, timeout_o, fail_idx_o, completed_o} !== '0) begin
      errors++; $display("FAIL reset_state: got %b expected all zero",
                         {child_start_o, busy_o, done_o, timeout_o, fail_idx_o, completed_o});
    end
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic test_all_children();
    run_seq("all_children", 5'b11111, 8'd16, '{2, 2, 2, 2, 2}, 5'b0, 0, 1);
  endtask

  task automatic test_sparse_mask();
    run_seq("sparse_mask", 5'b10100, 8'd16, '{3, 3, 1, 3, 5}, 5'b0, 0, 1);
  endtask

  task automatic test_empty_mask();
    run_seq("empty_mask", 5'b00000, 8'd16, '{1, 1, 1, 1, 1}, 5'b0, 0, 1);
  endtask

  task automatic test_timeout();
    run_seq("timeout", 5'b00011, 8'd4, '{2, 0, 1, 1, 1}, 5'b0, 0, 1);
  endtask

  task automatic test_ignored_inputs();
    // go held, stray done[3], and child 1 answering on the final timeout cycle
    run_seq("ignored_inputs", 5'b00011, 8'd4, '{2, 4, 1, 1, 1}, 5'b01000, 1, 1);
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit got2;
    int launch[NC];
    @(posedge clk); #1;
    for (int i = 0; i < NC; i++) launch[i] = -1;
    mask_i = 5'b11111; timeout_limit_i = 8'd0; go_i = 1'b1; cyc = 0; got2 = 0;
    while (!got2 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      go_i = 1'b0;
      for (int i = 0; i < NC; i++) if (child_start_o[i]) launch[i] = cyc;
      got2 = child_start_o[2];
      child_done_i = '0;
      for (int i = 0; i < 2; i++) if (launch[i] >= 0 && cyc == launch[i] + 2) child_done_i[i] = 1'b1;
    end
    checks++;
    if (!got2 || cyc != 9) begin
      errors++; $display("FAIL reset_mid start2: got seen=%b cyc=%0d expected seen=1 cyc=9", got2, cyc);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b1 || completed_o !== 5'b00011) begin
      errors++; $display("FAIL reset_mid pre: got busy=%b comp=%b expected 1 00011", busy_o, completed_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({child_start_o, busy_o, done_o, timeout_o, fail_idx_o, completed_o} !== '0) begin
      errors++; $display("FAIL reset_mid outputs: got %b expected all zero",
                         {child_start_o, busy_o, done_o, timeout_o, fail_idx_o, completed_o});
    end
    @(posedge clk); #3 rst = 1'b0;
    checks++;
    if (done_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid no_done: got %b expected 0", done_o);
    end
    run_seq("reset_mid_rerun", 5'b00100, 8'd8, '{1, 1, 2, 1, 1}, 5'b0, 0, 1);
  endtask

  task automatic test_random();
    logic [NC-1:0] mask, noise;
    logic [7:0] limit;
    int dly[NC];
    for (int r = 0; r < 10; r++) begin
      mask  = NC'($urandom_range(0, 31));
      limit = 8'($urandom_range(0, 8));
      for (int i = 0; i < NC; i++) dly[i] = $urandom_range(1, 10);
      if (limit != 0 && $urandom_range(0, 2) == 0) dly[$urandom_range(0, NC - 1)] = 0;
      noise = NC'($urandom_range(0, 31)) & ~mask;
      // back-to-back: go lands in the IDLE cycle straight after FINISH
      run_seq($sformatf("random_%0d", r), mask, limit, dly, noise, r[0], 0);
    end
  endtask

  initial begin
    test_reset();
    test_all_children();
    test_sparse_mask();
    test_empty_mask();
    test_timeout();
    test_ignored_inputs();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
